// File: rtl/spi_master_rx.sv
// ---------------------------------------------------------------------------
// spi_master_rx : SPI host receive deserialiser (single/quad) to 32-bit words
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_master_rx #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             rx_edge,
  input  logic             sdi0,
  input  logic             sdi1,
  input  logic             sdi2,
  input  logic             sdi3,
  input  logic             en_quad_in,
  input  logic [CNT_W-1:0] counter_in,
  input  logic             counter_in_upd,
  output logic [31:0]      data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             clk_en_o,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVE   = 2'd1,
    WAIT_FIFO = 2'd2,
    WAIT_LAST = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      shift_q;
  logic [31:0]      data_q;
  logic             valid_q;
  logic             clk_en_q;
  logic             done_q;

  logic [CNT_W-1:0] beats;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      shift_d;
  logic             word_end;
  logic             last_beat;

  // Word boundaries are counted from the start of the transfer; only the
  // final word can be short, so a modulo test on the running count suffices.
  always_comb begin
    beats     = en_quad_in ? (target_q >> 2) : target_q;
    shift_d   = en_quad_in ? {shift_q[27:0], sdi3, sdi2, sdi1, sdi0}
                           : {shift_q[30:0], sdi1};
    cnt_d     = cnt_q + 1'b1;
    word_end  = en_quad_in ? (cnt_d[2:0] == 3'd0) : (cnt_d[4:0] == 5'd0);
    last_beat = (cnt_d == beats);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      target_q <= CNT_W'(32);
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (counter_in_upd) target_q <= counter_in;
          if (en) begin
            if (beats == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= RECEIVE;
              cnt_q    <= '0;
              shift_q  <= '0;
              clk_en_q <= 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (rx_edge) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (word_end || last_beat) begin
              data_q   <= shift_d;
              valid_q  <= 1'b1;
              clk_en_q <= 1'b0;
              state_q  <= last_beat ? WAIT_LAST : WAIT_FIFO;
            end
          end
        end
        WAIT_FIFO: begin
          if (valid_q && data_ready) begin
            valid_q  <= 1'b0;
            shift_q  <= '0;
            clk_en_q <= 1'b1;
            state_q  <= RECEIVE;
          end
        end
        WAIT_LAST: begin
          if (valid_q && data_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign clk_en_o   = clk_en_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: doc/spi_master_rx.md
Name: spi_master_rx

Overview:
- Host-side SPI receive datapath: samples the data lines driven by the SPI device transmitter, in single or quad mode, and deserialises them into 32-bit words.
- Sits under the SPI master controller, next to the master clock generator. The generator supplies the `rx_edge` sample strobe. This block returns `clk_en_o` to stall sclk when the consumer applies backpressure.
- Received words leave on a valid/ready interface towards the master RX FIFO.

Parameters:
- CNT_W, 16, width of the transfer-length input (bits per transfer).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rstn  input  1  asynchronous active-low reset
- en  input  1  start request; sampled in IDLE only
- rx_edge  input  1  single-cycle sample strobe from the clock generator (sclk sampling edge)
- sdi0  input  1  data line IO0 (quad only)
- sdi1  input  1  data line IO1 (MISO in single mode; quad bit 1)
- sdi2  input  1  data line IO2 (quad only)
- sdi3  input  1  data line IO3 (quad only)
- en_quad_in  input  1  1 = quad (4 bits per rx_edge), 0 = single (1 bit per rx_edge); must be stable during a transfer
- counter_in  input  CNT_W  transfer length in bits
- counter_in_upd  input  1  load pulse for counter_in
- data  output  32  received word
- data_valid  output  1  data holds an unconsumed word
- data_ready  input  1  consumer accepts data when data_valid=1
- clk_en_o  output  1  sclk enable to the clock generator
- done  output  1  single-cycle pulse when the transfer is complete

Behaviour:

Reset (rstn=0, asynchronous):
- Outputs: data=0, data_valid=0, clk_en_o=0, done=0.
- State: IDLE, beat counter=0, shift register=0, target=32 bits.
- Reset mid-transfer aborts immediately. No done pulse and no partial word are produced.

Target and beats:
- Target register loads counter_in on counter_in_upd, only while in IDLE. The pulse is ignored in every other state.
- Beats per transfer: single mode = target; quad mode = target>>2. A non-multiple-of-4 target in quad mode truncates.
- Beats per word: 32 in single mode, 8 in quad mode.

Sampling (RECEIVE state, rx_edge=1):
- Quad: shift <= {shift[27:0], sdi3, sdi2, sdi1, sdi0}.
- Single: shift <= {shift[30:0], sdi1}.
- Beat counter increments on each sample.
- The first received bit ends up MSB-most, so the word is MSB-first.

FSM states: IDLE, RECEIVE, WAIT_FIFO, WAIT_LAST.
- IDLE, clk_en_o=0: en=1 moves to RECEIVE, clears the counter and shift register, and sets clk_en_o=1 from the next cycle. If beats=0, go directly to a done pulse and stay in IDLE; no word is produced.
- RECEIVE: on an rx_edge that completes a word, or that is the final beat:
  - Load data with the post-shift value and set data_valid=1 on the next cycle.
  - Set clk_en_o=0 on the next cycle.
  - Go to WAIT_LAST if this was the final beat, else WAIT_FIFO.
- WAIT_FIFO, clk_en_o=0: when data_valid and data_ready, clear data_valid, clear the shift register, set clk_en_o=1 and return to RECEIVE. rx_edge in this state is ignored.
- WAIT_LAST, clk_en_o=0: when data_valid and data_ready, clear data_valid, pulse done for one cycle and go to IDLE.

Partial final word:
- When the transfer length is not a multiple of 32 bits, the last word is right-aligned: valid bits sit in the LSBs and upper bits are 0.

Handshake rules:
- data and data_valid are registered and held stable until accepted.
- data_ready with data_valid=0 has no effect.
- Acceptance is at most one word per cycle.

Other conditions:
- en while not in IDLE is ignored.
- rx_edge in IDLE is ignored.
- en_quad_in is sampled on every beat; changing it mid-transfer is a software error and the resulting data is undefined.
- Beat counter is CNT_W wide and cannot wrap, since target ≤ 2^CNT_W-1.

Latency:
- Last sample rx_edge at cycle N gives data_valid=1 at N+1.
- A handshake at cycle M gives done=1 at M+1 for the final word, or clk_en_o=1 at M+1 otherwise.

Test Plan:
- Single mode, counter_in=8, sdi1 serial 1,0,1,1,0,0,1,0 on 8 rx_edges, data_ready=1 -> data=0x000000B2, data_valid one cycle after 8th edge, done pulses once, back to IDLE.
- Quad mode, counter_in=32, nibbles 0xD,0xE,0xA,0xD,0xB,0xE,0xE,0xF -> data=0xDEADBEEF after 8 rx_edges; clk_en_o drops, done after handshake.
- Single mode, counter_in=64, data_ready held 0 for 20 cycles after first word:
  - clk_en_o=0 and data stable throughout; rx_edges injected meanwhile are ignored.
  - After the handshake, clk_en_o returns to 1 and the second word completes correctly.
  - Exactly 2 words are delivered and 1 done pulse.
- Quad mode, counter_in=12, nibbles 0x1,0x2,0x3 -> single word data=0x00000123, done after handshake.
- Reset asserted after 5 of 8 beats -> data_valid=0, clk_en_o=0, done never pulses; a new 8-bit transfer afterwards produces the correct word.
- counter_in_upd with counter_in=4 during RECEIVE of a 16-bit transfer -> ignored, 16 bits received; counter_in=0 then en in IDLE -> done pulse, no data_valid.
